// File: rtl/disp_pkg.sv
// Shared display definitions: sample/BCD widths, decimal ceiling, clamp helper and FSM states.
package disp_pkg;

  localparam int unsigned DISP_DATA_W    = 20;
  localparam int unsigned DISP_BCD_W     = 24;
  localparam int unsigned DISP_MAX_VALUE = 999_999;

  typedef enum logic {
    DISP_IDLE = 1'b0,
    DISP_SHOW = 1'b1
  } disp_state_e;

  // Limit a sample to what six decimal digits can show.
  function automatic logic [DISP_DATA_W-1:0] clamp_disp(input logic [DISP_DATA_W-1:0] value);
    return (value > DISP_DATA_W'(DISP_MAX_VALUE)) ? DISP_DATA_W'(DISP_MAX_VALUE) : value;
  endfunction

endpackage

// File: rtl/disp_sync_fifo.sv
// Circular single-clock FIFO with registered occupancy; head word is read combinationally.
module disp_sync_fifo
  import disp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DISP_DATA_W,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [DATA_WIDTH-1:0]        i_wr_data,
  output logic [DATA_WIDTH-1:0]        o_rd_data_c,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_full_c,
  output logic                         o_empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full_c    = (o_level == LVL_W'(DEPTH));
  assign o_empty_c   = (o_level == '0);
  assign w_do_push   = i_push & ~o_full_c;
  assign w_do_pop    = i_pop & ~o_empty_c;
  assign o_rd_data_c = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      o_level <= o_level + LVL_W'(1);
      else if (!w_do_push && w_do_pop) o_level <= o_level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/disp_value_buffer.sv
// Queues producer samples and presents each, clamped to six decimal digits, for a fixed dwell
// time with a read_enable strobe for the downstream BCD converter.
module disp_value_buffer
  import disp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DISP_DATA_W,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned RE_CYCLES   = 4096,
  parameter int unsigned MAX_VALUE   = DISP_MAX_VALUE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        drop_clr,
  output logic [DATA_WIDTH-1:0]       buff_out,
  output logic                        read_enable,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic                        drop_flag
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RE_W   = $clog2(RE_CYCLES + 1);

  disp_state_e       r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [RE_W-1:0]   r_re_cnt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_clamped;

  disp_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_wr_data   (in_data),
    .o_rd_data_c (w_head),
    .o_level     (level),
    .o_full_c    (w_full),
    .o_empty_c   (w_empty)
  );

  assign in_ready  = ~w_full;
  assign w_push    = in_valid & in_ready;
  // Pop from IDLE, or back-to-back from SHOW on the cycle the dwell expires.
  assign w_pop     = ~w_empty & ((r_state == DISP_IDLE) || (r_hold_cnt == '0));
  assign w_clamped = (w_head > DATA_WIDTH'(MAX_VALUE)) ? DATA_WIDTH'(MAX_VALUE) : w_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= DISP_IDLE;
      r_hold_cnt  <= '0;
      r_re_cnt    <= '0;
      buff_out    <= '0;
      read_enable <= 1'b0;
    end else if (w_pop) begin
      r_state     <= DISP_SHOW;
      r_hold_cnt  <= HOLD_W'(HOLD_CYCLES - 1);
      r_re_cnt    <= RE_W'(RE_CYCLES - 1);
      buff_out    <= w_clamped;
      read_enable <= 1'b1;
    end else if (r_state == DISP_SHOW) begin
      if (r_hold_cnt == '0) begin
        r_state     <= DISP_IDLE;
        read_enable <= 1'b0;
      end else begin
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
        if (r_re_cnt == '0) read_enable <= 1'b0;
        else                r_re_cnt    <= r_re_cnt - RE_W'(1);
      end
    end
  end

  // Sticky overflow indicator; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       drop_flag <= 1'b0;
    else if (in_valid && w_full)   drop_flag <= 1'b1;
    else if (drop_clr)             drop_flag <= 1'b0;
  end

endmodule

// File: tb/tb_disp_value_buffer.sv
// Directed bench for disp_value_buffer with a short dwell (20), strobe (4) and depth (4).
module tb_disp_value_buffer;

  logic        clk;
  logic        rst;
  logic [19:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        drop_clr;
  logic [19:0] buff_out;
  logic        read_enable;
  logic [2:0]  level;
  logic        drop_flag;

  int n_cmp;
  int n_err;

  disp_value_buffer #(
    .DATA_WIDTH  (20),
    .DEPTH       (4),
    .HOLD_CYCLES (20),
    .RE_CYCLES   (4),
    .MAX_VALUE   (999_999)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .drop_clr    (drop_clr),
    .buff_out    (buff_out),
    .read_enable (read_enable),
    .level       (level),
    .drop_flag   (drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle push offer.
  task automatic offer(input logic [19:0] v);
    in_data  = v;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  logic [19:0] clamp_vec [3];
  logic [19:0] clamp_exp [3];
  int          re_cnt;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    drop_clr = 1'b0;
    clamp_vec[0] = 20'd1_048_575; clamp_exp[0] = 20'd999_999;
    clamp_vec[1] = 20'd999_999;   clamp_exp[1] = 20'd999_999;
    clamp_vec[2] = 20'd0;         clamp_exp[2] = 20'd0;

    tick(2);
    check("rst_buff",  32'(buff_out), 0);
    check("rst_re",    32'(read_enable), 0);
    check("rst_level", 32'(level), 0);
    check("rst_drop",  32'(drop_flag), 0);
    check("rst_ready", 32'(in_ready), 1);
    rst = 1'b0;
    tick(1);

    // Single sample: two-cycle latency, strobe exactly four cycles.
    offer(20'd123456);
    check("lat_level1", 32'(level), 1);
    check("lat_re0",    32'(read_enable), 0);
    tick(1);
    check("lat_buff",   32'(buff_out), 123456);
    check("lat_re1",    32'(read_enable), 1);
    check("lat_level0", 32'(level), 0);
    re_cnt = 1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (read_enable) re_cnt++;
    end
    check("re_width", 32'(re_cnt), 4);
    tick(12);
    check("idle_keep_buff", 32'(buff_out), 123456);
    check("idle_re",        32'(read_enable), 0);

    // Clamp at load time.
    for (int k = 0; k < 3; k++) begin
      offer(clamp_vec[k]);
      tick(1);
      check($sformatf("clamp_%0d", k), 32'(buff_out), 32'(clamp_exp[k]));
      tick(20);
    end

    // Back-to-back A then B with no gap at dwell expiry.
    offer(20'd111);
    offer(20'd222);
    check("ab_buffA", 32'(buff_out), 111);
    check("ab_level", 32'(level), 1);
    tick(19);
    check("ab_holdA", 32'(buff_out), 111);
    tick(1);
    check("ab_buffB",  32'(buff_out), 222);
    check("ab_reB",    32'(read_enable), 1);
    check("ab_level0", 32'(level), 0);
    tick(23);
    check("ab_keepB", 32'(buff_out), 222);
    check("ab_re_lo", 32'(read_enable), 0);

    // Fill while showing X; overflow and drop flag handling.
    offer(20'd7);
    tick(1);
    check("fill_showX", 32'(buff_out), 7);
    for (int k = 1; k <= 4; k++) offer(20'(k * 10));
    check("full_level", 32'(level), 4);
    check("full_ready", 32'(in_ready), 0);
    offer(20'd50);
    check("ovf_drop",  32'(drop_flag), 1);
    check("ovf_level", 32'(level), 4);
    in_data  = 20'd60;
    in_valid = 1'b1;
    drop_clr = 1'b1;
    tick(1);
    check("set_beats_clr", 32'(drop_flag), 1);
    in_valid = 1'b0;
    tick(1);
    drop_clr = 1'b0;
    check("drop_cleared", 32'(drop_flag), 0);
    // Now at X-load + 7; offer on the dwell-expiry edge (X-load + 20).
    tick(12);
    offer(20'd70);
    check("popfull_level", 32'(level), 3);
    check("popfull_drop",  32'(drop_flag), 1);
    check("popfull_buff",  32'(buff_out), 10);
    check("popfull_re",    32'(read_enable), 1);
    check("popfull_ready", 32'(in_ready), 1);

    // Reset mid-SHOW with three queued samples.
    rst = 1'b1;
    tick(1);
    check("mid_rst_buff",  32'(buff_out), 0);
    check("mid_rst_re",    32'(read_enable), 0);
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_ready", 32'(in_ready), 1);
    check("mid_rst_drop",  32'(drop_flag), 0);
    rst = 1'b0;
    tick(3);
    check("post_rst_buff", 32'(buff_out), 0);
    check("post_rst_lvl",  32'(level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
